// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single packet-SRAM controller port: round robin, full/empty rejection, completion watchdog.
// Define SRAM_ARB_HOST_PRIO_EN to make the host (port 0) win every tie instead of alternating.
module sram_arbiter #(
  parameter int DW             = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TW             = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s0_read,
  input  logic          s0_write,
  input  logic [DW-1:0] s0_wdata,
  output logic [DW-1:0] s0_rdata,
  output logic          s0_hint,
  output logic          s0_err,
  input  logic          s1_read,
  input  logic          s1_write,
  input  logic [DW-1:0] s1_wdata,
  output logic [DW-1:0] s1_rdata,
  output logic          s1_hint,
  output logic          s1_err,
  output logic          m_read,
  output logic          m_write,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_hint,
  input  logic          m_full,
  input  logic          m_empty,
  output logic          owner,
  output logic          busy,
  output logic          timeout_flag
);

  typedef enum logic [2:0] {IDLE, ISSUE, REJECT, ACK, GUARD} state_t;

  state_t        state_reg, state_next;
  logic          last_reg, last_next;
  logic          owner_reg, owner_next;
  logic          op_wr_reg, op_wr_next;
  logic          err_reg, err_next;
  logic [TW-1:0] cnt_reg, cnt_next;
  logic          m_read_reg, m_read_next;
  logic          m_write_reg, m_write_next;
  logic [DW-1:0] m_wdata_reg, m_wdata_next;
  logic [DW-1:0] rdata_reg [2];
  logic [DW-1:0] rdata_next [2];
  logic [1:0]    hint_reg, hint_next;
  logic [1:0]    serr_reg, serr_next;
  logic          busy_reg, busy_next;
  logic          tflag_reg, tflag_next;

  logic [1:0] req;
  logic [1:0] wr;
  logic       grant;

  assign req = {s1_read | s1_write, s0_read | s0_write};
  assign wr  = {s1_write, s0_write};

  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    owner_next    = owner_reg;
    op_wr_next    = op_wr_reg;
    err_next      = err_reg;
    cnt_next      = cnt_reg;
    m_read_next   = m_read_reg;
    m_write_next  = m_write_reg;
    m_wdata_next  = m_wdata_reg;
    rdata_next[0] = rdata_reg[0];
    rdata_next[1] = rdata_reg[1];
    tflag_next    = tflag_reg;
    grant         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          if (req == 2'b11) begin
`ifdef SRAM_ARB_HOST_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_reg;
`endif
          end else begin
            grant = req[1];
          end
          owner_next = grant;
          op_wr_next = wr[grant];
          if (wr[grant] ? m_full : m_empty) begin
            state_next = REJECT;
          end else begin
            state_next   = ISSUE;
            m_wdata_next = grant ? s1_wdata : s0_wdata;
            m_write_next = wr[grant];
            m_read_next  = ~wr[grant];
            cnt_next     = '0;
          end
        end
      end
      ISSUE: begin
        // A hint arriving on the last allowed cycle still counts as success.
        if (m_hint) begin
          m_read_next  = 1'b0;
          m_write_next = 1'b0;
          err_next     = 1'b0;
          if (!op_wr_reg) rdata_next[owner_reg] = m_rdata;
          state_next   = ACK;
        end else if (cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          m_read_next  = 1'b0;
          m_write_next = 1'b0;
          err_next     = 1'b1;
          tflag_next   = 1'b1;
          if (!op_wr_reg) rdata_next[owner_reg] = '1;
          state_next   = ACK;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      REJECT: begin
        err_next   = 1'b1;
        state_next = ACK;
      end
      ACK: begin
        last_next  = owner_reg;
        state_next = GUARD;
      end
      GUARD:   state_next = IDLE;
      default: state_next = IDLE;
    endcase

    hint_next = 2'b00;
    if (state_next == ACK) hint_next[owner_next] = 1'b1;
    serr_next = hint_next & {2{err_next}};
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      owner_reg    <= 1'b0;
      op_wr_reg    <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
      m_read_reg   <= 1'b0;
      m_write_reg  <= 1'b0;
      m_wdata_reg  <= '0;
      rdata_reg[0] <= '0;
      rdata_reg[1] <= '0;
      hint_reg     <= 2'b00;
      serr_reg     <= 2'b00;
      busy_reg     <= 1'b0;
      tflag_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      owner_reg    <= owner_next;
      op_wr_reg    <= op_wr_next;
      err_reg      <= err_next;
      cnt_reg      <= cnt_next;
      m_read_reg   <= m_read_next;
      m_write_reg  <= m_write_next;
      m_wdata_reg  <= m_wdata_next;
      rdata_reg[0] <= rdata_next[0];
      rdata_reg[1] <= rdata_next[1];
      hint_reg     <= hint_next;
      serr_reg     <= serr_next;
      busy_reg     <= busy_next;
      tflag_reg    <= tflag_next;
    end
  end

  assign s0_rdata     = rdata_reg[0];
  assign s1_rdata     = rdata_reg[1];
  assign s0_hint      = hint_reg[0];
  assign s1_hint      = hint_reg[1];
  assign s0_err       = serr_reg[0];
  assign s1_err       = serr_reg[1];
  assign m_read       = m_read_reg;
  assign m_write      = m_write_reg;
  assign m_wdata      = m_wdata_reg;
  assign owner        = owner_reg;
  assign busy         = busy_reg;
  assign timeout_flag = tflag_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: transaction-level model predicts grant order and responses;
// an SRAM responder and a hint monitor check the DUT independently of the stimulus driver.
module tb_sram_arbiter;
  localparam int DW = 16;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s0_read = 0, s0_write = 0, s1_read = 0, s1_write = 0;
  logic [DW-1:0] s0_wdata = 0, s1_wdata = 0;
  logic [DW-1:0] s0_rdata, s1_rdata, m_wdata;
  logic s0_hint, s0_err, s1_hint, s1_err, m_read, m_write;
  logic [DW-1:0] m_rdata = 0;
  logic resp_hint = 0, stray_hint = 0;
  logic m_hint;
  logic m_full = 0, m_empty = 0;
  logic owner, busy, timeout_flag;

  assign m_hint = resp_hint | stray_hint;

  sram_arbiter #(.DW(DW), .TIMEOUT_CYCLES(T), .TW(4)) dut (
    .clk(clk), .reset(reset),
    .s0_read(s0_read), .s0_write(s0_write), .s0_wdata(s0_wdata),
    .s0_rdata(s0_rdata), .s0_hint(s0_hint), .s0_err(s0_err),
    .s1_read(s1_read), .s1_write(s1_write), .s1_wdata(s1_wdata),
    .s1_rdata(s1_rdata), .s1_hint(s1_hint), .s1_err(s1_err),
    .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_hint(m_hint), .m_full(m_full), .m_empty(m_empty),
    .owner(owner), .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; bit both; logic [DW-1:0] wdata; int lat; logic [DW-1:0] rdata; } tx_t;
  typedef struct { bit wr; logic [DW-1:0] wdata; int lat; logic [DW-1:0] rdata; } plan_t;
  typedef struct { bit port; bit err; logic [DW-1:0] rdata; bit tflag; } exp_t;

  tx_t   stim0[$], stim1[$];
  plan_t plan_q[$];
  exp_t  exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference state: round-robin pointer, sticky timeout, last rdata per port.
  bit            m_last = 1'b1;
  bit            m_tflag = 1'b0;
  logic [DW-1:0] m_rd [2] = '{16'h0, 16'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Walks both request lists in the order the arbitration rules dictate.
  task automatic model_round(input bit full, input bit empty);
    tx_t q0[$], q1[$];
    tx_t t;
    exp_t e;
    bit p;
    q0 = stim0;
    q1 = stim1;
    while (q0.size() > 0 || q1.size() > 0) begin
      if (q0.size() > 0 && q1.size() > 0) begin
`ifdef SRAM_ARB_HOST_PRIO_EN
        p = 1'b0;
`else
        p = ~m_last;
`endif
      end else begin
        p = (q0.size() > 0) ? 1'b0 : 1'b1;
      end
      t = p ? q1.pop_front() : q0.pop_front();
      m_last = p;
      e.port = p;
      if (t.wr ? full : empty) begin
        e.err = 1'b1;
      end else begin
        plan_q.push_back('{wr: t.wr, wdata: t.wdata, lat: t.lat, rdata: t.rdata});
        if (t.lat <= T) begin
          e.err = 1'b0;
          if (!t.wr) m_rd[p] = t.rdata;
        end else begin
          e.err = 1'b1;
          m_tflag = 1'b1;
          if (!t.wr) m_rd[p] = 16'hFFFF;
        end
      end
      e.rdata = m_rd[p];
      e.tflag = m_tflag;
      exp_q.push_back(e);
    end
  endtask

  task automatic apply(input bit p);
    tx_t t;
    bit have;
    have = p ? (stim1.size() > 0) : (stim0.size() > 0);
    t = '{wr: 0, both: 0, wdata: 0, lat: 0, rdata: 0};
    if (have) t = p ? stim1[0] : stim0[0];
    if (!p) begin
      s0_write = have & t.wr;
      s0_read  = have & (~t.wr | t.both);
      s0_wdata = t.wdata;
    end else begin
      s1_write = have & t.wr;
      s1_read  = have & (~t.wr | t.both);
      s1_wdata = t.wdata;
    end
  endtask

  task automatic add_tx(input bit p, input bit wr, input bit both, input logic [DW-1:0] wd,
                        input int lat, input logic [DW-1:0] rd);
    if (!p) stim0.push_back('{wr: wr, both: both, wdata: wd, lat: lat, rdata: rd});
    else    stim1.push_back('{wr: wr, both: both, wdata: wd, lat: lat, rdata: rd});
  endtask

  // Called on a negedge; returns the negedge count at which the first hint appeared.
  task automatic run_round(input bit full, input bit empty, output int first_hint);
    int n;
    model_round(full, empty);
    m_full = full;
    m_empty = empty;
    apply(0);
    apply(1);
    n = 0;
    first_hint = -1;
    while ((stim0.size() > 0 || stim1.size() > 0) && n < 400) begin
      @(negedge clk);
      n++;
      if (s0_hint) begin
        if (first_hint < 0) first_hint = n;
        if (stim0.size() > 0) void'(stim0.pop_front());
        apply(0);
      end
      if (s1_hint) begin
        if (first_hint < 0) first_hint = n;
        if (stim1.size() > 0) void'(stim1.pop_front());
        apply(1);
      end
    end
    chk("round_complete", {31'd0, n < 400}, 32'd1);
    repeat (3) @(negedge clk);
    m_full = 1'b0;
    m_empty = 1'b0;
  endtask

  // SRAM controller model: answers each strobe after the planned latency.
  initial begin
    plan_t cur;
    int cnt;
    bit active;
    active = 1'b0;
    cnt = 0;
    cur = '{wr: 0, wdata: 0, lat: 1000, rdata: 0};
    forever begin
      @(posedge clk);
      resp_hint <= 1'b0;
      if (reset) begin
        active = 1'b0;
      end else if (m_read || m_write) begin
        if (!active) begin
          if (plan_q.size() == 0) begin
            chk("unexpected_strobe", 32'd1, 32'd0);
            cur = '{wr: m_write, wdata: m_wdata, lat: 1000, rdata: 0};
          end else begin
            cur = plan_q.pop_front();
          end
          chk("strobe_type", {30'd0, m_read, m_write}, cur.wr ? 32'd1 : 32'd2);
          m_rdata <= cur.rdata;
          active = 1'b1;
          cnt = 1;
        end else begin
          cnt++;
        end
        if (cur.wr) chk("m_wdata", {16'd0, m_wdata}, {16'd0, cur.wdata});
        if (cnt == cur.lat - 1) resp_hint <= 1'b1;
      end else if (active) begin
        chk("strobe_len", cnt, (cur.lat < T) ? cur.lat : T);
        active = 1'b0;
      end
    end
  end

  // Completion monitor: every hint must match the next predicted response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int p = 0; p < 2; p++) begin
          if (p == 0 ? s0_hint : s1_hint) begin
            if (exp_q.size() == 0) begin
              chk("spurious_hint", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("hint_port", p, {31'd0, e.port});
              chk("hint_err", {31'd0, p == 0 ? s0_err : s1_err}, {31'd0, e.err});
              chk("hint_rdata", {16'd0, p == 0 ? s0_rdata : s1_rdata}, {16'd0, e.rdata});
              chk("hint_tflag", {31'd0, timeout_flag}, {31'd0, e.tflag});
              chk("hint_owner", {31'd0, owner}, p);
              $display("txn port=%0d err=%0d rdata=%h tflag=%0d", p, e.err, e.rdata, e.tflag);
            end
          end
        end
      end
    end
  end

  initial begin
    int fh;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {24'd0, m_read, m_write, s0_hint, s1_hint, s0_err, s1_err, busy, timeout_flag}, 32'd0);
    chk("rst_rdata", {s0_rdata, s1_rdata}, 32'd0);
    chk("rst_misc", {15'd0, owner, m_wdata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Contention right after reset: host first, then strict alternation.
    add_tx(0, 0, 0, 16'h0000, 2, 16'hA001);
    add_tx(0, 0, 0, 16'h0000, 3, 16'hA002);
    add_tx(1, 1, 0, 16'hB001, 2, 16'h0000);
    add_tx(1, 1, 1, 16'hB002, 4, 16'h0000);
    run_round(0, 0, fh);

    // Host-only write, SRAM answers after 3 strobe cycles.
    add_tx(0, 1, 0, 16'h2DD4, 3, 16'h0000);
    run_round(0, 0, fh);

    // Radio read data must persist through a later host access.
    add_tx(1, 0, 0, 16'h0000, 3, 16'h1234);
    run_round(0, 0, fh);
    add_tx(0, 1, 0, 16'h5555, 2, 16'h0000);
    run_round(0, 0, fh);
    chk("s1_rdata_hold", {16'd0, s1_rdata}, 32'h1234);

    // Full / empty rejection: hint two cycles after the request, no strobe.
    add_tx(0, 1, 0, 16'h7777, 3, 16'h0000);
    run_round(1, 0, fh);
    chk("reject_full_lat", fh, 2);
    add_tx(0, 0, 0, 16'h0000, 3, 16'h9999);
    run_round(0, 1, fh);
    chk("reject_empty_lat", fh, 2);

    // Hint on the final allowed cycle wins; a silent SRAM times out.
    add_tx(1, 0, 0, 16'h0000, T, 16'h4321);
    run_round(0, 0, fh);
    add_tx(0, 0, 0, 16'h0000, 1000, 16'h0000);
    run_round(0, 0, fh);
    repeat (5) @(negedge clk);
    chk("tflag_sticky", {31'd0, timeout_flag}, 32'd1);

    // Stray SRAM hint while idle must be ignored.
    stray_hint = 1'b1;
    @(negedge clk);
    stray_hint = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of an access.
    add_tx(0, 0, 0, 16'h0000, 50, 16'h0000);
    model_round(0, 0);
    apply(0);
    repeat (4) @(negedge clk);
    chk("pre_reset_strobe", {31'd0, m_read}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_outputs", {27'd0, m_read, m_write, busy, s0_hint, s1_hint}, 32'd0);
    chk("mid_reset_tflag", {31'd0, timeout_flag}, 32'd0);
    stim0.delete();
    plan_q.delete();
    exp_q.delete();
    apply(0);
    m_last = 1'b1;
    m_tflag = 1'b0;
    m_rd[0] = 16'h0;
    m_rd[1] = 16'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    add_tx(0, 0, 0, 16'h0000, 3, 16'hC0DE);
    add_tx(1, 1, 0, 16'hD00D, 2, 16'h0000);
    run_round(0, 0, fh);

    // Randomised rounds.
    for (int r = 0; r < 40; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      for (int i = 0; i < n0; i++)
        add_tx(0, 1'($urandom % 2), 1'($urandom % 2), 16'($urandom), $urandom_range(2, 10), 16'($urandom));
      for (int i = 0; i < n1; i++)
        add_tx(1, 1'($urandom % 2), 1'($urandom % 2), 16'($urandom), $urandom_range(2, 10), 16'($urandom));
      run_round(($urandom % 6) == 0, ($urandom % 6) == 0, fh);
    end

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("plan_q_drained", plan_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
